aemb_dwb_lsu: RTL and testbench

//  Data-side load/store unit directly downstream of the execute ALU. Takes the registered

---
 rtl/aemb_dwb_if.sv | 25 ++
 rtl/aemb_dwb_lsu.sv | 114 +++++++++++
 tb/tb_aemb_dwb_lsu.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aemb_dwb_if.sv
// Wishbone classic data-bus bundle between the LSU and data memory.
// The master drives address/select/data/strobe; the slave returns data and ack.
interface aemb_dwb_if #(
  parameter int DW = 32
);
  logic [DW-1:2] dwb_adr_o;
  logic [3:0]    dwb_sel_o;
  logic [31:0]   dwb_dat_o;
  logic          dwb_wre_o;
  logic          dwb_stb_o;
  logic [31:0]   dwb_dat_i;
  logic          dwb_ack_i;

  modport master (
    output dwb_adr_o, dwb_sel_o, dwb_dat_o,
    output dwb_wre_o, dwb_stb_o,
    input  dwb_dat_i, dwb_ack_i
  );

  modport slave (
    input  dwb_adr_o, dwb_sel_o, dwb_dat_o,
    input  dwb_wre_o, dwb_stb_o,
    output dwb_dat_i, dwb_ack_i
  );
endinterface

// File: rtl/aemb_dwb_lsu.sv
// Data-side load/store unit: one Wishbone classic cycle per access,
// stalls execute until ack or timeout, returns lane-aligned load data.
module aemb_dwb_lsu #(
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          rSTB,
  input  logic          rWE,
  input  logic [1:0]    rSIZ,
  input  logic [DW-1:2] rADR,
  input  logic [3:0]    rSEL,
  input  logic [31:0]   rDAT,
  aemb_dwb_if.master    dwb,
  output logic          dstall_o,
  output logic [31:0]   rDWBDI,
  output logic          dwb_err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  rState;
  logic [15:0] rCnt;
  logic        wAck;
  logic        wTmo;
  logic [31:0] wFmt;
  logic [31:0] wAlign;

  always_comb begin
    wAck = (rState == BUSY) & dwb.dwb_ack_i;
    wTmo = (rState == BUSY) & ~dwb.dwb_ack_i &
           (TMO != 0) & (rCnt == 16'(TMO - 1));
  end

  // Reset also releases the stall so the pipeline is not held in reset.
  always_comb begin
    if (rState == IDLE)
      dstall_o = ~grst & rSTB;
    else
      dstall_o = ~grst & ~(wAck | wTmo);
  end

  always_comb begin
    unique case (rSIZ)
      2'd0:    wFmt = {4{rDAT[7:0]}};
      2'd1:    wFmt = {2{rDAT[15:0]}};
      default: wFmt = rDAT;
    endcase
  end

  always_comb begin
    unique case (dwb.dwb_sel_o)
      4'h8:    wAlign = {24'd0, dwb.dwb_dat_i[31:24]};
      4'h4:    wAlign = {24'd0, dwb.dwb_dat_i[23:16]};
      4'h2:    wAlign = {24'd0, dwb.dwb_dat_i[15:8]};
      4'h1:    wAlign = {24'd0, dwb.dwb_dat_i[7:0]};
      4'hC:    wAlign = {16'd0, dwb.dwb_dat_i[31:16]};
      4'h3:    wAlign = {16'd0, dwb.dwb_dat_i[15:0]};
      default: wAlign = dwb.dwb_dat_i;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      rState        <= IDLE;
      rCnt          <= '0;
      dwb.dwb_adr_o <= '0;
      dwb.dwb_sel_o <= '0;
      dwb.dwb_dat_o <= '0;
      dwb.dwb_wre_o <= 1'b0;
      dwb.dwb_stb_o <= 1'b0;
      rDWBDI        <= '0;
      dwb_err_o     <= 1'b0;
    end else begin
      dwb_err_o <= 1'b0;
      unique case (rState)
        IDLE: begin
          if (rSTB) begin
            dwb.dwb_adr_o <= rADR;
            dwb.dwb_sel_o <= rSEL;
            dwb.dwb_wre_o <= rWE;
            dwb.dwb_dat_o <= wFmt;
            dwb.dwb_stb_o <= 1'b1;
            rCnt          <= '0;
            rState        <= BUSY;
          end
        end
        BUSY: begin
          if (wAck) begin
            if (!dwb.dwb_wre_o)
              rDWBDI <= wAlign;
            dwb.dwb_stb_o <= 1'b0;
            dwb.dwb_wre_o <= 1'b0;
            rCnt          <= '0;
            rState        <= IDLE;
          end else if (wTmo) begin
            rDWBDI        <= '0;
            dwb_err_o     <= 1'b1;
            dwb.dwb_stb_o <= 1'b0;
            dwb.dwb_wre_o <= 1'b0;
            rCnt          <= '0;
            rState        <= IDLE;
          end else begin
            rCnt <= rCnt + 16'd1;
          end
        end
        default: rState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_dwb_lsu.sv
// Randomized bench for aemb_dwb_lsu against a transaction-level model,
// plus directed cases with literal expectations.
module tb_aemb_dwb_lsu;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic        gclk = 1'b0;
  logic        grst;
  logic        rSTB;
  logic        rWE;
  logic [1:0]  rSIZ;
  logic [29:0] rADR;
  logic [3:0]  rSEL;
  logic [31:0] rDAT;
  logic        dstall_o;
  logic [31:0] rDWBDI;
  logic        dwb_err_o;

  aemb_dwb_if #(.DW(DW)) bus ();

  aemb_dwb_lsu #(.DW(DW), .TMO(TMO)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .rSTB      (rSTB),
    .rWE       (rWE),
    .rSIZ      (rSIZ),
    .rADR      (rADR),
    .rSEL      (rSEL),
    .rDAT      (rDAT),
    .dwb       (bus),
    .dstall_o  (dstall_o),
    .rDWBDI    (rDWBDI),
    .dwb_err_o (dwb_err_o)
  );

  always #5 gclk = ~gclk;

  int n_chk = 0;
  int n_fail = 0;

  logic        e_stb, e_wre, e_stall, e_err, e_wre_chk;
  logic [29:0] e_adr;
  logic [3:0]  e_sel;
  logic [31:0] e_dat, e_rd;

  logic [31:0] m_rd;
  logic        m_err;
  logic        abort_last;

  int          c_stb, c_stall, c_err;
  logic [31:0] last_dat_o;
  logic        last_wre;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [1:0] siz,
                                      input logic [31:0] d);
    if (siz == 2'd0) return 32'(d[7:0]) * 32'h01010101;
    if (siz == 2'd1) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] align(input logic [3:0] sel,
                                        input logic [31:0] d);
    int wbits;
    int lo;
    if (sel == 4'h8 || sel == 4'h4 || sel == 4'h2 || sel == 4'h1)
      wbits = 8;
    else if (sel == 4'hC || sel == 4'h3)
      wbits = 16;
    else
      return d;
    lo = 0;
    for (int i = 3; i >= 0; i--)
      if (sel[i]) lo = i;
    return (d >> (8 * lo)) & ((32'd1 << wbits) - 32'd1);
  endfunction

  // Per-cycle compare at the falling edge, then resync to posedge+1.
  task automatic tick();
    @(negedge gclk);
    chk("stb", 32'(bus.dwb_stb_o), 32'(e_stb));
    chk("dstall", 32'(dstall_o), 32'(e_stall));
    chk("err", 32'(dwb_err_o), 32'(e_err));
    chk("rDWBDI", rDWBDI, e_rd);
    if (e_wre_chk) chk("wre", 32'(bus.dwb_wre_o), 32'(e_wre));
    if (e_stb) begin
      chk("adr", 32'(bus.dwb_adr_o), 32'(e_adr));
      chk("sel", 32'(bus.dwb_sel_o), 32'(e_sel));
      chk("dat_o", bus.dwb_dat_o, e_dat);
    end
    if (bus.dwb_stb_o) begin
      c_stb++;
      last_dat_o = bus.dwb_dat_o;
      last_wre = bus.dwb_wre_o;
    end
    if (dstall_o) c_stall++;
    if (dwb_err_o) c_err++;
    @(posedge gclk);
    #1;
  endtask

  task automatic clr();
    c_stb = 0;
    c_stall = 0;
    c_err = 0;
  endtask

  task automatic idle(input int n);
    rSTB = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.dwb_ack_i = 1'($urandom_range(0, 1));
      bus.dwb_dat_i = $urandom;
      e_stb = 0; e_stall = 0; e_err = m_err; e_rd = m_rd;
      e_wre = 0; e_wre_chk = !abort_last;
      tick();
      m_err = 0;
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] siz,
                     input logic [29:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input int w,
                     input logic [31:0] din);
    rSTB = 1'b1; rWE = we; rSIZ = siz;
    rADR = adr; rSEL = sel; rDAT = dat;
    bus.dwb_ack_i = 1'($urandom_range(0, 1));
    bus.dwb_dat_i = $urandom;
    e_stb = 0; e_stall = 1; e_err = m_err; e_rd = m_rd;
    e_wre = 0; e_wre_chk = !abort_last;
    tick();
    m_err = 0;
    for (int k = 0; k < 64; k++) begin
      logic ack;
      logic abt;
      ack = (k == w);
      abt = !ack && (k == TMO - 1);
      bus.dwb_ack_i = ack;
      bus.dwb_dat_i = ack ? din : $urandom;
      e_stb = 1; e_adr = adr; e_sel = sel; e_dat = fmt(siz, dat);
      e_wre = we; e_wre_chk = 1;
      e_stall = !(ack || abt); e_err = 0; e_rd = m_rd;
      tick();
      if (ack) begin
        if (!we) m_rd = align(sel, din);
        abort_last = 0;
        break;
      end
      if (abt) begin
        m_rd = 0;
        m_err = 1;
        abort_last = 1;
        break;
      end
    end
    rSTB = 1'b0;
    bus.dwb_ack_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        we;
    logic [1:0]  siz;
    logic [3:0]  sel;
    grst = 1'b1; rSTB = 0; rWE = 0; rSIZ = 0;
    rADR = 0; rSEL = 0; rDAT = 0;
    bus.dwb_ack_i = 0; bus.dwb_dat_i = 0;
    m_rd = 0; m_err = 0; abort_last = 0;
    clr();
    #12;
    chk("rst_stb", 32'(bus.dwb_stb_o), 32'd0);
    chk("rst_wre", 32'(bus.dwb_wre_o), 32'd0);
    chk("rst_sel", 32'(bus.dwb_sel_o), 32'd0);
    chk("rst_adr", 32'(bus.dwb_adr_o), 32'd0);
    chk("rst_dat", bus.dwb_dat_o, 32'd0);
    chk("rst_rd", rDWBDI, 32'd0);
    chk("rst_err", 32'(dwb_err_o), 32'd0);
    chk("rst_stall", 32'(dstall_o), 32'd0);
    @(negedge gclk);
    grst = 1'b0;
    @(posedge gclk);
    #1;

    clr();
    txn(0, 2'd0, 30'h40, 4'h4, $urandom, 0, 32'hAABBCCDD);
    chk("bl_rd", rDWBDI, 32'h000000BB);
    chk("bl_stb_cyc", c_stb, 1);
    chk("bl_stall_cyc", c_stall, 1);
    idle(1);

    clr();
    txn(1, 2'd1, 30'h80, 4'h3, 32'h12345678, 3, $urandom);
    chk("hs_dat", last_dat_o, 32'h56785678);
    chk("hs_wre", 32'(last_wre), 32'd1);
    chk("hs_stall_cyc", c_stall, 4);
    chk("hs_rd", rDWBDI, 32'h000000BB);
    idle(1);
    chk("hs_noerr", c_err, 0);

    clr();
    txn(0, 2'd2, 30'h10, 4'hF, $urandom, 0, 32'hDEADBEEF);
    chk("wl_rd1", rDWBDI, 32'hDEADBEEF);
    txn(0, 2'd2, 30'h11, 4'hF, $urandom, 1, 32'h0BADF00D);
    chk("wl_rd2", rDWBDI, 32'h0BADF00D);
    chk("wl_stb_cyc", c_stb, 3);
    idle(1);

    clr();
    txn(0, 2'd2, 30'h20, 4'hF, $urandom, 100, 32'h0);
    chk("to_stb_cyc", c_stb, TMO);
    chk("to_rd", rDWBDI, 32'd0);
    idle(2);
    chk("to_err_cyc", c_err, 1);

    txn(0, 2'd2, 30'h30, 4'hF, $urandom, 0, 32'h13579BDF);
    chk("pre_rst_rd", rDWBDI, 32'h13579BDF);
    rSTB = 1; rWE = 0; rSIZ = 2'd2; rADR = 30'h31; rSEL = 4'hF;
    e_stb = 0; e_stall = 1; e_err = 0; e_rd = m_rd;
    e_wre = 0; e_wre_chk = 1;
    tick();
    bus.dwb_ack_i = 0;
    chk("busy_stb", 32'(bus.dwb_stb_o), 32'd1);
    #2;
    grst = 1'b1;
    #1;
    chk("mr_stb", 32'(bus.dwb_stb_o), 32'd0);
    chk("mr_stall", 32'(dstall_o), 32'd0);
    chk("mr_rd", rDWBDI, 32'd0);
    rSTB = 0;
    grst = 1'b0;
    m_rd = 0; m_err = 0; abort_last = 0;
    @(posedge gclk);
    #1;
    idle(4);

    for (int n = 0; n < 120; n++) begin
      we = 1'($urandom_range(0, 1));
      siz = 2'($urandom_range(0, 3));
      if (siz == 2'd0) sel = 4'(1 << $urandom_range(0, 3));
      else if (siz == 2'd1) sel = $urandom_range(0, 1) ? 4'hC : 4'h3;
      else if (siz == 2'd2) sel = 4'hF;
      else sel = 4'($urandom_range(0, 15));
      txn(we, siz, 30'($urandom), sel, $urandom,
          $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
